cymometer_calc: RTL and testbench

Measurement back end of the equal-precision frequency meter, on the reference-clock side. It consumes the gate already synchronised to clk_fs, counts clk_fs cycles while the gate is high, then runs a serial division. The result is the frequency of the measured signal: fx = GATE_TIME * CLK_FS_HZ / cnt_fs. It sits directly downstream of the gate generator and drives display/UART logic through a one-cycle valid strobe.

---
 rtl/cymometer_pkg.sv | 21 ++
 rtl/cymometer_calc_if.sv | 39 +++
 rtl/cymometer_calc_seq_divider.sv | 64 ++++++
 rtl/cymometer_calc.sv | 126 ++++++++++++
 tb/tb_cymometer_calc.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cymometer_pkg.sv
// Shared types and constants for the reference-clock side of the frequency meter.
// The default clock/gate constants must agree with the gate generator.
package cymometer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam longint unsigned DEF_CLK_FS_HZ = 64'd50_000_000;
    localparam longint unsigned DEF_GATE_TIME = 64'd5;

    // fx = GATE_TIME * CLK_FS_HZ / cnt_fs, so the numerator is a build-time constant.
    function automatic longint unsigned calc_dividend(input longint unsigned gate_time,
                                                      input longint unsigned clk_hz);
        return gate_time * clk_hz;
    endfunction

endpackage

// File: rtl/cymometer_calc_if.sv
// Gate input and result outputs of cymometer_calc.
// CYMO_CNT_OUT_EN adds the cnt_fs_out debug/averaging bus.
interface cymometer_calc_if #(
    parameter int DATA_W = 32
`ifdef CYMO_CNT_OUT_EN
    , parameter int CNT_W = 32
`endif
) ();
    logic              gate_fs;
    logic [DATA_W-1:0] data_fx;
    logic              data_valid;
    logic              busy;
    logic              overflow;
`ifdef CYMO_CNT_OUT_EN
    logic [CNT_W-1:0]  cnt_fs_out;
`endif

    modport master (
        output gate_fs,
        input  data_fx,
        input  data_valid,
        input  busy,
        input  overflow
`ifdef CYMO_CNT_OUT_EN
        , input cnt_fs_out
`endif
    );

    modport slave (
        input  gate_fs,
        output data_fx,
        output data_valid,
        output busy,
        output overflow
`ifdef CYMO_CNT_OUT_EN
        , output cnt_fs_out
`endif
    );
endinterface

// File: rtl/cymometer_calc_seq_divider.sv
// Restoring serial divider: one quotient bit per clock, exactly NUM_W cycles from
// i_start to the o_done pulse. The remainder stays narrower than the divisor + 1 bit.
module seq_divider #(
    parameter int NUM_W = 64,
    parameter int DEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_dividend,
    input  logic [DEN_W-1:0] i_divisor,
    output logic [NUM_W-1:0] o_quotient,
    output logic             o_done,
    output logic             o_busy
);
    localparam int CW = $clog2(NUM_W + 1);

    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [DEN_W-1:0] r_den;
    logic [DEN_W-1:0] r_rem;
    logic [NUM_W-1:0] r_quo;

    logic [DEN_W:0]   w_shift;
    logic             w_ge;

    assign w_shift = {r_rem, r_quo[NUM_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_den});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_cnt  <= r_cnt + CW'(1);
            r_done <= (r_cnt == CW'(NUM_W - 1));
            r_busy <= (r_cnt != CW'(NUM_W - 1));
        end else begin
            r_done <= 1'b0;
        end
    end

    // Quotient bits shift in from the bottom as dividend bits leave from the top.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_den <= i_divisor;
            r_rem <= '0;
            r_quo <= i_dividend;
        end else if (r_busy) begin
            r_rem <= w_ge ? DEN_W'(w_shift - {1'b0, r_den}) : w_shift[DEN_W-1:0];
            r_quo <= {r_quo[NUM_W-2:0], w_ge};
        end
    end

    assign o_quotient = r_quo;
    assign o_done     = r_done;
    assign o_busy     = r_busy;
endmodule

// File: rtl/cymometer_calc.sv
// Equal-precision frequency meter back end: counts clk_fs cycles across the gate and
// divides GATE_TIME*CLK_FS_HZ by that count. Optional feature macro: CYMO_CNT_OUT_EN.
module cymometer_calc
    import cymometer_pkg::*;
#(
    parameter longint unsigned CLK_FS_HZ = DEF_CLK_FS_HZ,
    parameter longint unsigned GATE_TIME = DEF_GATE_TIME,
    parameter int              CNT_W     = 32,
    parameter int              DATA_W    = 32,
    parameter int              NUM_W     = 64
) (
    input  logic              clk_fs,
    input  logic              rst_n,
    cymometer_calc_if.slave   bus
);
    localparam logic [NUM_W-1:0] DIVIDEND = NUM_W'(calc_dividend(GATE_TIME, CLK_FS_HZ));

    state_t             r_state;
    state_t             w_next;
    logic               r_gate_d1;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cnt_sat;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_ovf;

    logic               w_rise;
    logic               w_fall;
    logic               w_start;
    logic [NUM_W-1:0]   w_quo;
    logic               w_div_done;
    logic               w_div_busy;

    function automatic logic quo_over(input logic [NUM_W-1:0] q);
        return (q >> DATA_W) != '0;
    endfunction

    function automatic logic [DATA_W-1:0] sat_quo(input logic [NUM_W-1:0] q);
        return quo_over(q) ? '1 : q[DATA_W-1:0];
    endfunction

    assign w_rise  = bus.gate_fs & ~r_gate_d1;
    assign w_fall  = ~bus.gate_fs & r_gate_d1;
    assign w_start = (r_state == COUNT) && w_fall && !w_div_busy;

    always_ff @(posedge clk_fs) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gate_d1 <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_gate_d1 <= bus.gate_fs;
        end
    end

    // A gate already high on entry to IDLE produces no rise, so it is never measured.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_rise)     w_next = COUNT;
            COUNT:   if (w_fall)     w_next = DIV;
            DIV:     if (w_div_done) w_next = DONE;
            DONE:                    w_next = IDLE;
            default:                 w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_fs) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_cnt_sat <= 1'b0;
        end else if (r_state == IDLE && w_rise) begin
            r_cnt     <= CNT_W'(1);
            r_cnt_sat <= 1'b0;
        end else if (r_state == COUNT && bus.gate_fs) begin
            if (&r_cnt) r_cnt_sat <= 1'b1;
            else        r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W)
    ) u_div (
        .clk        (clk_fs),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_dividend (DIVIDEND),
        .i_divisor  (r_cnt),
        .o_quotient (w_quo),
        .o_done     (w_div_done),
        .o_busy     (w_div_busy)
    );

    // Result registers load on the same edge the FSM enters DONE.
    always_ff @(posedge clk_fs) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == DIV && w_div_done) begin
                r_valid <= 1'b1;
                r_data  <= sat_quo(w_quo);
                r_ovf   <= r_cnt_sat | quo_over(w_quo);
            end
        end
    end

`ifdef CYMO_CNT_OUT_EN
    logic [CNT_W-1:0] r_cnt_out;

    always_ff @(posedge clk_fs) begin
        if (!rst_n)                             r_cnt_out <= '0;
        else if (r_state == DIV && w_div_done)  r_cnt_out <= r_cnt;
    end

    assign bus.cnt_fs_out = r_cnt_out;
`endif

    assign bus.data_fx    = r_data;
    assign bus.data_valid = r_valid;
    assign bus.overflow   = r_ovf;
    assign bus.busy       = (r_state == COUNT) || (r_state == DIV);
endmodule

// File: tb/tb_cymometer_calc.sv
// Bench for cymometer_calc: three configurations (default, CNT_W=8, DATA_W=16) share one
// gate stream and are compared every cycle against an arithmetic model of the meter.
module tb_cymometer_calc;
    localparam longint DIVD = 64'd250_000_000;

    logic clk_fs = 1'b0;
    logic rst_n  = 1'b0;
    logic gate   = 1'b0;

    always #5 clk_fs = ~clk_fs;

    int total = 0;
    int bad   = 0;

`ifdef CYMO_CNT_OUT_EN
    cymometer_calc_if #(.DATA_W(32), .CNT_W(32)) if0 ();
    cymometer_calc_if #(.DATA_W(32), .CNT_W(8))  if1 ();
    cymometer_calc_if #(.DATA_W(16), .CNT_W(32)) if2 ();
`else
    cymometer_calc_if #(.DATA_W(32)) if0 ();
    cymometer_calc_if #(.DATA_W(32)) if1 ();
    cymometer_calc_if #(.DATA_W(16)) if2 ();
`endif

    assign if0.gate_fs = gate;
    assign if1.gate_fs = gate;
    assign if2.gate_fs = gate;

    cymometer_calc dut0 (.clk_fs(clk_fs), .rst_n(rst_n), .bus(if0));
    cymometer_calc #(.CNT_W(8))   dut1 (.clk_fs(clk_fs), .rst_n(rst_n), .bus(if1));
    cymometer_calc #(.DATA_W(16)) dut2 (.clk_fs(clk_fs), .rst_n(rst_n), .bus(if2));

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     ph  = 0;      // 0 waiting for a fresh gate, 1 gate open, 2 dividing, 3 result cycle
    longint n   = 0;
    longint tf  = 0;
    longint cyc = 0;
    logic   gp  = 1'b0;
    logic   e_valid = 1'b0;
    logic   e_busy  = 1'b0;
    longint e_data [3];
    logic   e_ov   [3];
    longint e_cnt  [3];

    function automatic longint cnt_cap(input int i);
        return (i == 1) ? 64'd255 : 64'hFFFF_FFFF;
    endfunction

    function automatic longint data_max(input int i);
        return (i == 2) ? 64'd65535 : 64'hFFFF_FFFF;
    endfunction

    task automatic model_step();
        longint d;
        longint q;
        cyc++;
        e_valid = 1'b0;
        if (!rst_n) begin
            ph = 0;
            gp = 1'b0;
            for (int i = 0; i < 3; i++) begin
                e_data[i] = 0; e_ov[i] = 1'b0; e_cnt[i] = 0;
            end
        end else begin
            case (ph)
                0: if (gate && !gp) begin n = 1; ph = 1; end
                1: if (gate) n++; else begin tf = cyc; ph = 2; end
                2: if (cyc == tf + 65) begin
                       ph = 3;
                       e_valid = 1'b1;
                       for (int i = 0; i < 3; i++) begin
                           d = (n > cnt_cap(i)) ? cnt_cap(i) : n;
                           q = DIVD / d;
                           e_ov[i]  = (n > cnt_cap(i)) || (q > data_max(i));
                           e_data[i] = (q > data_max(i)) ? data_max(i) : q;
                           e_cnt[i]  = d;
                       end
                   end
                default: ph = 0;
            endcase
            gp = gate;
        end
        e_busy = (ph == 1) || (ph == 2);
    endtask

    initial forever begin
        @(posedge clk_fs);
        model_step();
    end

    // ---------------- per-cycle comparison ----------------
    initial forever begin
        @(negedge clk_fs);
        if (cyc > 0) begin
            chk("d0_valid", longint'(if0.data_valid), longint'(e_valid));
            chk("d0_busy",  longint'(if0.busy),       longint'(e_busy));
            chk("d0_data",  longint'(if0.data_fx),    e_data[0]);
            chk("d0_ovf",   longint'(if0.overflow),   longint'(e_ov[0]));
            chk("d1_valid", longint'(if1.data_valid), longint'(e_valid));
            chk("d1_busy",  longint'(if1.busy),       longint'(e_busy));
            chk("d1_data",  longint'(if1.data_fx),    e_data[1]);
            chk("d1_ovf",   longint'(if1.overflow),   longint'(e_ov[1]));
            chk("d2_valid", longint'(if2.data_valid), longint'(e_valid));
            chk("d2_busy",  longint'(if2.busy),       longint'(e_busy));
            chk("d2_data",  longint'(if2.data_fx),    e_data[2]);
            chk("d2_ovf",   longint'(if2.overflow),   longint'(e_ov[2]));
`ifdef CYMO_CNT_OUT_EN
            chk("d0_cnt", longint'(if0.cnt_fs_out), e_cnt[0]);
            chk("d1_cnt", longint'(if1.cnt_fs_out), e_cnt[1]);
`endif
        end
    end

    int     vcount    = 0;
    longint last_data = 0;

    initial forever begin
        @(posedge clk_fs);
        #1;
        if (if0.data_valid) begin
            vcount++;
            last_data = longint'(if0.data_fx);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic pulse_gate(input int len);
        @(negedge clk_fs);
        gate = 1'b1;
        repeat (len) @(negedge clk_fs);
        gate = 1'b0;
    endtask

    // Returns edges counted from the fall-detect edge to the edge that raises data_valid.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk_fs);
            #1;
            lat++;
            if (if0.data_valid) return;
        end
        chk("valid_timeout", 0, 1);
    endtask

    task automatic measure(input int len, input longint exp0, input longint exp1,
                           input logic ov1, input longint exp2, input logic ov2);
        int lat;
        pulse_gate(len);
        wait_valid(lat);
        chk("latency",  lat, 65);
        chk("lit_d0",   longint'(if0.data_fx),  exp0);
        chk("lit_d0ov", longint'(if0.overflow), 0);
        chk("lit_d1",   longint'(if1.data_fx),  exp1);
        chk("lit_d1ov", longint'(if1.overflow), longint'(ov1));
        chk("lit_d2",   longint'(if2.data_fx),  exp2);
        chk("lit_d2ov", longint'(if2.overflow), longint'(ov2));
        repeat (4) @(negedge clk_fs);
    endtask

    initial begin
        int v0;
        rst_n = 1'b0;
        gate  = 1'b0;
        repeat (3) @(negedge clk_fs);
        chk("rst_data",  longint'(if0.data_fx),    0);
        chk("rst_valid", longint'(if0.data_valid), 0);
        chk("rst_busy",  longint'(if0.busy),       0);
        chk("rst_ovf",   longint'(if0.overflow),   0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_fs);

        measure(500, 500_000,     980_392,     1'b1, 65_535, 1'b1);
        measure(1,   250_000_000, 250_000_000, 1'b0, 65_535, 1'b1);
        measure(3,   83_333_333,  83_333_333,  1'b0, 65_535, 1'b1);
        measure(255, 980_392,     980_392,     1'b0, 65_535, 1'b1);

        // Gate activity during the divide is ignored; a gate held high into IDLE is not measured.
        v0 = vcount;
        pulse_gate(500);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_fs);
            gate = k[0];
        end
        gate = 1'b1;
        repeat (200) @(negedge clk_fs);
        gate = 1'b0;
        repeat (100) @(negedge clk_fs);
        chk("toggle_count", vcount - v0, 1);
        chk("toggle_data",  last_data, 500_000);

        // Reset in the 20th divide cycle aborts the measurement.
        v0 = vcount;
        pulse_gate(10);
        repeat (20) @(negedge clk_fs);
        rst_n = 1'b0;
        @(negedge clk_fs);
        rst_n = 1'b1;
        chk("abort_data", longint'(if0.data_fx),  0);
        chk("abort_busy", longint'(if0.busy),     0);
        chk("abort_ovf",  longint'(if1.overflow), 0);
        repeat (120) @(negedge clk_fs);
        chk("abort_count", vcount - v0, 0);

        for (int r = 0; r < 40; r++) begin
            gate = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 350)) @(negedge clk_fs);
        end
        gate = 1'b0;
        repeat (200) @(negedge clk_fs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "bench time limit reached");
    end
endmodule
